// File: rtl/edge_bbox.sv
// Edge bounding box: accumulates the min/max column and row of edge pixels
// over one in_vs-delimited frame. It publishes the box, the edge count and a
// validity flag once per completed frame, with a one-cycle frame_done pulse.
module edge_bbox #(
    parameter logic [10:0] IMG_HDISP = 11'd1280,
    parameter logic [10:0] IMG_VDISP = 11'd720,
    parameter logic [20:0] MIN_EDGES = 21'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic        in_bit,
    output logic [10:0] x_min,
    output logic [10:0] x_max,
    output logic [10:0] y_min,
    output logic [10:0] y_max,
    output logic [20:0] edge_count,
    output logic        box_valid,
    output logic        frame_done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [10:0] COORD_ONES = '1;
    localparam logic [20:0] COUNT_MAX  = '1;

    state_t      state, state_nxt;
    logic        vs_d, de_d;
    logic [10:0] hcnt, vcnt;
    logic [20:0] count;
    logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;

    logic vs_fall, vs_rise, de_fall;
    logic start_frame, close_frame, run, pix_ok;

    assign vs_fall = vs_d & ~in_vs;
    assign vs_rise = ~vs_d & in_vs;
    assign de_fall = de_d & ~in_de;

    // Delay sync and data-enable by one cycle for edge detection.
    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= in_vs;
            de_d <= in_de;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the frame start/close/run strobes for the datapath.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        close_frame = 1'b0;
        run         = 1'b0;
        case (state)
            IDLE: begin
                if (vs_fall && EN) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (!EN) begin
                    // Aborted frame: leave quietly, results untouched.
                    state_nxt = IDLE;
                end else if (vs_rise) begin
                    state_nxt   = IDLE;
                    close_frame = 1'b1;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pixel counts only inside the active window; the closing cycle is excluded via run.
    assign pix_ok = run && in_de && in_bit && !in_vs &&
                    (hcnt < IMG_HDISP) && (vcnt < IMG_VDISP);

    // Position counters, edge count and box accumulators for the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            count    <= '0;
            acc_xmin <= COORD_ONES;
            acc_xmax <= '0;
            acc_ymin <= COORD_ONES;
            acc_ymax <= '0;
        end else if (start_frame) begin
            hcnt     <= '0;
            vcnt     <= '0;
            count    <= '0;
            acc_xmin <= COORD_ONES;
            acc_xmax <= '0;
            acc_ymin <= COORD_ONES;
            acc_ymax <= '0;
        end else if (run) begin
            if (in_de) begin
                if (hcnt < IMG_HDISP) hcnt <= hcnt + 11'd1;
            end else if (de_fall) begin
                hcnt <= '0;
                if (vcnt < IMG_VDISP) vcnt <= vcnt + 11'd1;
            end
            if (pix_ok) begin
                if (hcnt < acc_xmin) acc_xmin <= hcnt;
                if (hcnt > acc_xmax) acc_xmax <= hcnt;
                if (vcnt < acc_ymin) acc_ymin <= vcnt;
                if (vcnt > acc_ymax) acc_ymax <= vcnt;
                if (count != COUNT_MAX) count <= count + 21'd1;
            end
        end
    end

    // Publish results on frame close; they hold until the next completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            edge_count <= '0;
            box_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (close_frame) begin
                frame_done <= 1'b1;
                edge_count <= count;
                if (count >= MIN_EDGES) begin
                    x_min     <= acc_xmin;
                    x_max     <= acc_xmax;
                    y_min     <= acc_ymin;
                    y_max     <= acc_ymax;
                    box_valid <= 1'b1;
                end else begin
                    x_min     <= '0;
                    x_max     <= '0;
                    y_min     <= '0;
                    y_max     <= '0;
                    box_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_bbox.sv
// Scoreboard bench for edge_bbox: frames are described as a 2-D edge map,
// a reference model derives the expected result from the map, and a monitor
// compares it against each frame_done pulse.
module tb_edge_bbox;

    localparam int H   = 8;
    localparam int V   = 6;
    localparam int MIN = 2;

    typedef struct packed {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [20:0] cnt;
        logic        valid;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        in_vs = 1'b0;
    logic        in_de = 1'b0;
    logic        in_bit = 1'b0;
    logic [10:0] x_min, x_max, y_min, y_max;
    logic [20:0] edge_count;
    logic        box_valid, frame_done;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_exp    = 0;
    int   n_done   = 0;
    res_t exp_q[$];
    res_t last_exp = '0;
    res_t zero_r   = '0;
    bit   bits[16][16];

    edge_bbox #(
        .IMG_HDISP(11'd8),
        .IMG_VDISP(11'd6),
        .MIN_EDGES(21'd2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (en),
        .in_vs     (in_vs),
        .in_de     (in_de),
        .in_bit    (in_bit),
        .x_min     (x_min),
        .x_max     (x_max),
        .y_min     (y_min),
        .y_max     (y_max),
        .edge_count(edge_count),
        .box_valid (box_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input res_t e);
        check({tag, ".x_min"},      32'(x_min),      32'(e.xmin));
        check({tag, ".x_max"},      32'(x_max),      32'(e.xmax));
        check({tag, ".y_min"},      32'(y_min),      32'(e.ymin));
        check({tag, ".y_max"},      32'(y_max),      32'(e.ymax));
        check({tag, ".edge_count"}, 32'(edge_count), 32'(e.cnt));
        check({tag, ".box_valid"},  32'(box_valid),  32'(e.valid));
    endtask

    // Reference: edge at line l, pixel p counts when p < H and l < V.
    function automatic res_t model(input int nl, input int len);
        res_t r;
        int cnt = 0, xmn = 1 << 20, xmx = -1, ymn = 1 << 20, ymx = -1;
        for (int l = 0; l < nl; l++)
            for (int p = 0; p < len; p++)
                if (bits[l][p] && p < H && l < V) begin
                    cnt++;
                    if (p < xmn) xmn = p;
                    if (p > xmx) xmx = p;
                    if (l < ymn) ymn = l;
                    if (l > ymx) ymx = l;
                end
        r = '0;
        r.cnt = 21'(cnt);
        if (cnt >= MIN) begin
            r.xmin  = 11'(xmn);
            r.xmax  = 11'(xmx);
            r.ymin  = 11'(ymn);
            r.ymax  = 11'(ymx);
            r.valid = 1'b1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bits();
        for (int l = 0; l < 16; l++)
            for (int p = 0; p < 16; p++)
                bits[l][p] = 1'b0;
    endtask

    // One frame: blanking, vs fall, nl lines of len pixels, vs rise.
    // drop_line / raise_line >= 0 toggle EN at the start of that line.
    task automatic drive_frame(input int nl, input int len, input int drop_line,
                               input int raise_line, input bit coll);
        res_t e;
        en = (raise_line < 0);
        in_vs = 1'b1; in_de = 1'b0; in_bit = 1'b0;
        repeat (3) tick();
        in_vs = 1'b0;
        tick();
        for (int l = 0; l < nl; l++) begin
            if (l == drop_line)  en = 1'b0;
            if (l == raise_line) en = 1'b1;
            for (int p = 0; p < len; p++) begin
                in_de = 1'b1;
                in_bit = bits[l][p];
                tick();
            end
            in_de = 1'b0; in_bit = 1'b0;
            tick();
            tick();
        end
        in_vs = 1'b1; in_de = coll; in_bit = coll;
        if (raise_line < 0 && drop_line < 0) begin
            e = model(nl, len);
            exp_q.push_back(e);
            last_exp = e;
            n_exp++;
        end
        tick();
        in_de = 1'b0; in_bit = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every frame_done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                check_outs("frame", exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #3;
        check_outs("reset", zero_r);
        check("reset.frame_done", 32'(frame_done), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Three edges spanning the window.
        clear_bits();
        bits[1][1] = 1; bits[4][6] = 1; bits[5][2] = 1;
        drive_frame(6, 8, -1, -1, 0);

        // Single edge: below MIN.
        clear_bits();
        bits[2][3] = 1;
        drive_frame(6, 8, -1, -1, 0);

        // Edges only beyond the line width, plus an extra 7th line.
        clear_bits();
        for (int l = 0; l < 7; l++) begin
            bits[l][8] = 1;
            bits[l][9] = 1;
        end
        drive_frame(7, 10, -1, -1, 0);

        // Full frame of edges, closed with a colliding pixel on vs rise.
        clear_bits();
        for (int l = 0; l < 6; l++)
            for (int p = 0; p < 8; p++)
                bits[l][p] = 1;
        drive_frame(6, 8, -1, -1, 1);

        // Valid frame, then EN dropped mid-frame, then EN raised mid-frame.
        clear_bits();
        bits[1][1] = 1; bits[4][6] = 1; bits[5][2] = 1;
        drive_frame(6, 8, -1, -1, 0);
        clear_bits();
        for (int l = 0; l < 6; l++) bits[l][l] = 1;
        drive_frame(6, 8, 2, -1, 0);
        check_outs("hold_after_abort", last_exp);
        drive_frame(6, 8, -1, 2, 0);
        check_outs("hold_after_late_en", last_exp);
        drive_frame(6, 8, -1, -1, 0);

        // Reset mid-frame discards the partial frame.
        en = 1'b1;
        in_vs = 1'b1;
        repeat (3) tick();
        in_vs = 1'b0;
        tick();
        in_de = 1'b1; in_bit = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", zero_r);
        last_exp = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        in_de = 1'b0; in_bit = 1'b0;
        tick();
        in_vs = 1'b1;
        repeat (4) tick();
        check_outs("after_reset_partial", zero_r);
        clear_bits();
        bits[0][7] = 1; bits[3][0] = 1;
        drive_frame(6, 8, -1, -1, 0);

        // Randomized frames, including oversized lines and frames.
        for (int f = 0; f < 24; f++) begin
            int nl, len;
            nl  = int'($urandom_range(0, 8));
            len = int'($urandom_range(1, 11));
            clear_bits();
            for (int l = 0; l < nl; l++)
                for (int p = 0; p < len; p++)
                    bits[l][p] = ($urandom_range(0, 3) == 0);
            drive_frame(nl, len, -1, -1, 1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        check("pending_results", 32'(exp_q.size()), 32'd0);
        check("frame_done_pulses", 32'(n_done), 32'(n_exp));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
